// File: rtl/atpg_bist_driver.sv
// LFSR pattern source and SISR response compactor for a single-output
// combinational ATPG core. One run applies NUM_PATTERNS patterns. The
// final signature is then compared against GOLDEN_SIG.
module atpg_bist_driver #(
   parameter int unsigned NUM_PATTERNS = 1024,
   parameter logic [15:0] SIG_INIT     = 16'hFFFF,
   parameter logic [15:0] GOLDEN_SIG   = 16'h0000
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        start,
   input  logic        seed_load,
   input  logic [12:0] seed,
   input  logic        dut_resp,
   output logic [12:0] pattern,
   output logic        dut_clr,
   output logic        busy,
   output logic        done,
   output logic [15:0] signature,
   output logic        pass
);

   localparam logic [12:0] LAST_COUNT = 13'(NUM_PATTERNS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [12:0] lfsr_q, lfsr_d;
   logic [12:0] count_q, count_d;
   logic [15:0] sig_q, sig_d;

   logic        lfsr_fb;
   logic [12:0] lfsr_next;
   logic        sisr_fb;
   logic [15:0] sisr_next;
   logic [12:0] seed_safe;

   // Next-value functions: x^13+x^4+x^3+x+1 LFSR and x^16+x^12+x^5+1 SISR.
   always_comb begin
      lfsr_fb   = lfsr_q[12] ^ lfsr_q[3] ^ lfsr_q[2] ^ lfsr_q[0];
      lfsr_next = {lfsr_q[11:0], lfsr_fb};
      sisr_fb   = sig_q[15] ^ dut_resp;
      sisr_next = {sig_q[14:0], 1'b0} ^ (sisr_fb ? 16'h1021 : 16'h0000);
      // An all-zero seed would lock the LFSR up, so it is replaced by 1.
      seed_safe = (seed == '0) ? 13'h0001 : seed;
   end

   // State and datapath registers, asynchronously cleared.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         lfsr_q  <= 13'h0001;
         count_q <= '0;
         sig_q   <= '0;
      end else begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         count_q <= count_d;
         sig_q   <= sig_d;
      end
   end

   // Next-state logic: start/seed_load only in IDLE/DONE; RUN steps both registers each cycle.
   always_comb begin
      state_d = state_q;
      lfsr_d  = lfsr_q;
      count_d = count_q;
      sig_d   = sig_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (seed_load) lfsr_d = seed_safe;
            if (start) begin
               state_d = RUN;
               sig_d   = SIG_INIT;
               count_d = '0;
            end
         end
         RUN: begin
            sig_d   = sisr_next;
            lfsr_d  = lfsr_next;
            count_d = count_q + 13'd1;
            if (count_q == LAST_COUNT) state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs come only from registers and the state decode.
   always_comb begin
      pattern   = lfsr_q;
      signature = sig_q;
      busy      = (state_q == RUN);
      dut_clr   = (state_q == RUN);
      done      = (state_q == DONE);
      pass      = (state_q == DONE) && (sig_q == GOLDEN_SIG);
   end

endmodule

// File: tb/tb_atpg_bist_driver.sv
// Bench for atpg_bist_driver. It has four instances:
//   A: 4-pattern run with golden 0x0E1F.
//   B: 4-pattern run with golden 0x0000. B shares A's stimulus.
//   D: 1-pattern run. D also shares A's stimulus.
//   C: full-period run driven by a behavioural core.
module tb_atpg_bist_driver;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic        rst, start, seed_load, resp;
   logic [12:0] seed;
   logic        start_c, seed_load_c, resp_c;
   logic [12:0] seed_c;

   logic [12:0] pat_a, pat_b, pat_c, pat_d;
   logic        clr_a, clr_b, clr_c, clr_d;
   logic        busy_a, busy_b, busy_c, busy_d;
   logic        done_a, done_b, done_c, done_d;
   logic [15:0] sig_a, sig_b, sig_c, sig_d;
   logic        pass_a, pass_b, pass_c, pass_d;

   int errors = 0;
   int checks = 0;
   logic [12:0] ma_lfsr;

   atpg_bist_driver #(.NUM_PATTERNS(4), .SIG_INIT(16'hFFFF), .GOLDEN_SIG(16'h0E1F)) u_a (
      .CLK(CLK), .RST(rst), .start(start), .seed_load(seed_load), .seed(seed),
      .dut_resp(resp), .pattern(pat_a), .dut_clr(clr_a), .busy(busy_a),
      .done(done_a), .signature(sig_a), .pass(pass_a));

   atpg_bist_driver #(.NUM_PATTERNS(4), .SIG_INIT(16'hFFFF), .GOLDEN_SIG(16'h0000)) u_b (
      .CLK(CLK), .RST(rst), .start(start), .seed_load(seed_load), .seed(seed),
      .dut_resp(resp), .pattern(pat_b), .dut_clr(clr_b), .busy(busy_b),
      .done(done_b), .signature(sig_b), .pass(pass_b));

   atpg_bist_driver #(.NUM_PATTERNS(1), .SIG_INIT(16'hFFFF), .GOLDEN_SIG(16'h0000)) u_d (
      .CLK(CLK), .RST(rst), .start(start), .seed_load(seed_load), .seed(seed),
      .dut_resp(resp), .pattern(pat_d), .dut_clr(clr_d), .busy(busy_d),
      .done(done_d), .signature(sig_d), .pass(pass_d));

   atpg_bist_driver #(.NUM_PATTERNS(8191), .SIG_INIT(16'hFFFF), .GOLDEN_SIG(16'h0000)) u_c (
      .CLK(CLK), .RST(rst), .start(start_c), .seed_load(seed_load_c), .seed(seed_c),
      .dut_resp(resp_c), .pattern(pat_c), .dut_clr(clr_c), .busy(busy_c),
      .done(done_c), .signature(sig_c), .pass(pass_c));

   // Behavioural stand-in for the combinational core; output forced low while CLR is low.
   function automatic logic core_f(input logic [12:0] p, input logic clr);
      return clr & ((p[0] & p[5]) ^ (p[3] | p[12]) ^ (^p[11:7]));
   endfunction

   assign resp_c = core_f(pat_c, clr_c);

   // Reference models: polynomial arithmetic on plain integers.
   function automatic logic [12:0] lfsr_step(input logic [12:0] l);
      int v;
      int fb;
      v  = int'(l);
      fb = $countones(l & 13'h100D) % 2;
      return 13'(((v << 1) | fb) & 'h1FFF);
   endfunction

   function automatic logic [15:0] sisr_step(input logic [15:0] s, input logic r);
      int v;
      v = int'(s) << 1;
      if ((((int'(s) >> 15) & 1) ^ int'(r)) != 0) v = v ^ 'h1021;
      return 16'(v);
   endfunction

   task automatic cyc();
      @(negedge CLK);
   endtask

   task automatic test_reset();
      cyc();
      seed = 13'h1234; seed_load = 1'b1; start = 1'b1;
      cyc();
      seed_load = 1'b0; start = 1'b0;
      cyc();
      checks++;
      if (busy_a !== 1'b1) begin
         errors++; $display("FAIL reset_prerun_busy: got %b expected 1", busy_a);
      end
      @(posedge CLK);
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({pat_a, sig_a, busy_a, done_a, pass_a, clr_a} !== {13'h0001, 16'h0000, 4'b0000}) begin
         errors++;
         $display("FAIL reset_a: got pat=%h sig=%h b/d/p/c=%b%b%b%b expected 0001 0000 0000",
                  pat_a, sig_a, busy_a, done_a, pass_a, clr_a);
      end
      checks++;
      if ({pat_d, sig_d, busy_d, done_d, pass_d, clr_d} !== {13'h0001, 16'h0000, 4'b0000}) begin
         errors++;
         $display("FAIL reset_d: got pat=%h sig=%h b/d/p/c=%b%b%b%b expected 0001 0000 0000",
                  pat_d, sig_d, busy_d, done_d, pass_d, clr_d);
      end
      cyc();
      rst = 1'b0;
      ma_lfsr = 13'h0001;
   endtask

   task automatic test_pattern_seq();
      logic [15:0] m_sig;
      cyc();
      seed = 13'h0001; seed_load = 1'b1; start = 1'b1; resp = 1'b0;
      checks++;
      if (busy_a !== 1'b0 || pass_a !== 1'b0) begin
         errors++; $display("FAIL seq_idle: got busy=%b pass=%b expected 0 0", busy_a, pass_a);
      end
      ma_lfsr = 13'h0001;
      m_sig   = 16'hFFFF;
      cyc();
      seed_load = 1'b0; start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (pat_a !== ma_lfsr) begin
            errors++; $display("FAIL seq_pattern%0d: got %h expected %h", k, pat_a, ma_lfsr);
         end
         checks++;
         if ({busy_a, clr_a, done_a, pass_a, pass_b} !== 5'b11000) begin
            errors++;
            $display("FAIL seq_run_flags%0d: got %b expected 11000", k,
                     {busy_a, clr_a, done_a, pass_a, pass_b});
         end
         checks++;
         if ({busy_d, done_d} !== ((k == 0) ? 2'b10 : 2'b01)) begin
            errors++; $display("FAIL num1_flags%0d: got %b", k, {busy_d, done_d});
         end
         m_sig   = sisr_step(m_sig, 1'b0);
         ma_lfsr = lfsr_step(ma_lfsr);
         cyc();
      end
      checks++;
      if ({done_a, busy_a, clr_a} !== 3'b100) begin
         errors++; $display("FAIL seq_done: got d/b/c=%b expected 100", {done_a, busy_a, clr_a});
      end
      checks++;
      if (sig_a !== 16'h0E1F) begin
         errors++; $display("FAIL seq_signature: got %h expected 0e1f", sig_a);
      end
      checks++;
      if (pass_a !== 1'b1 || pass_b !== 1'b0) begin
         errors++; $display("FAIL seq_pass: got a=%b b=%b expected 1 0", pass_a, pass_b);
      end
      checks++;
      if (sig_d !== sisr_step(16'hFFFF, 1'b0) || pass_d !== 1'b0) begin
         errors++; $display("FAIL num1_signature: got %h pass=%b expected efdf 0", sig_d, pass_d);
      end
      cyc();
      checks++;
      if (done_a !== 1'b1 || sig_a !== 16'h0E1F || pat_a !== ma_lfsr) begin
         errors++;
         $display("FAIL seq_hold: got d=%b sig=%h pat=%h expected 1 0e1f %h",
                  done_a, sig_a, pat_a, ma_lfsr);
      end
   endtask

   task automatic test_random_resp();
      logic [15:0] m_sig;
      logic        r;
      for (int run = 0; run < 6; run++) begin
         cyc();
         if (run % 2 == 0) begin
            seed = 13'($urandom);
            if (run == 4) seed = 13'h0000;
            seed_load = 1'b1;
            ma_lfsr = (seed == 13'h0000) ? 13'h0001 : seed;
         end
         start = 1'b1;
         cyc();
         start = 1'b0; seed_load = 1'b0;
         m_sig = 16'hFFFF;
         for (int k = 0; k < 4; k++) begin
            checks++;
            if (pat_a !== ma_lfsr) begin
               errors++; $display("FAIL rand_pattern r%0d k%0d: got %h expected %h", run, k, pat_a, ma_lfsr);
            end
            r       = 1'($urandom);
            resp    = r;
            m_sig   = sisr_step(m_sig, r);
            ma_lfsr = lfsr_step(ma_lfsr);
            cyc();
         end
         checks++;
         if (done_a !== 1'b1 || sig_a !== m_sig) begin
            errors++; $display("FAIL rand_signature r%0d: got done=%b sig=%h expected 1 %h", run, done_a, sig_a, m_sig);
         end
         checks++;
         if (pass_a !== (m_sig == 16'h0E1F) || pass_b !== (m_sig == 16'h0000)) begin
            errors++; $display("FAIL rand_pass r%0d: got a=%b b=%b sig=%h", run, pass_a, pass_b, m_sig);
         end
         resp = 1'b0;
      end
   endtask

   task automatic test_ignored();
      cyc();
      seed = 13'h0000; seed_load = 1'b1; start = 1'b0;
      cyc();
      seed_load = 1'b0;
      ma_lfsr = 13'h0001;
      checks++;
      if (done_a !== 1'b1 || pat_a !== 13'h0001) begin
         errors++; $display("FAIL zero_seed: got done=%b pat=%h expected 1 0001", done_a, pat_a);
      end
      start = 1'b1;
      cyc();
      start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (pat_a !== ma_lfsr || busy_a !== 1'b1) begin
            errors++; $display("FAIL ignore_run%0d: got pat=%h busy=%b expected %h 1", k, pat_a, busy_a, ma_lfsr);
         end
         if (k == 1) begin
            start = 1'b1; seed_load = 1'b1; seed = 13'($urandom) | 13'h0100;
         end else begin
            start = 1'b0; seed_load = 1'b0;
         end
         ma_lfsr = lfsr_step(ma_lfsr);
         cyc();
      end
      checks++;
      if (done_a !== 1'b1 || sig_a !== 16'h0E1F || pat_a !== ma_lfsr) begin
         errors++;
         $display("FAIL ignore_end: got done=%b sig=%h pat=%h expected 1 0e1f %h", done_a, sig_a, pat_a, ma_lfsr);
      end
   endtask

   task automatic test_reset_midrun();
      cyc();
      seed = 13'h0001; seed_load = 1'b1; start = 1'b1;
      cyc();
      seed_load = 1'b0; start = 1'b0;
      cyc();
      cyc();
      checks++;
      if (pat_a !== 13'h0007 || busy_a !== 1'b1) begin
         errors++; $display("FAIL midrun_pattern2: got pat=%h busy=%b expected 0007 1", pat_a, busy_a);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({busy_a, done_a, sig_a, pat_a} !== {2'b00, 16'h0000, 13'h0001}) begin
         errors++;
         $display("FAIL midrun_reset: got b=%b d=%b sig=%h pat=%h expected 0 0 0000 0001",
                  busy_a, done_a, sig_a, pat_a);
      end
      cyc();
      rst = 1'b0;
      ma_lfsr = 13'h0001;
      cyc();
      start = 1'b1;
      cyc();
      start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (pat_a !== ma_lfsr) begin
            errors++; $display("FAIL midrun_rerun%0d: got %h expected %h", k, pat_a, ma_lfsr);
         end
         ma_lfsr = lfsr_step(ma_lfsr);
         cyc();
      end
      checks++;
      if (done_a !== 1'b1 || sig_a !== 16'h0E1F) begin
         errors++; $display("FAIL midrun_final: got done=%b sig=%h expected 1 0e1f", done_a, sig_a);
      end
   endtask

   task automatic test_period();
      logic [15:0] m_sig;
      logic [12:0] mp;
      bit          seen [8192];
      int          repeats;
      int          bad;
      int          n;
      repeats = 0; bad = 0; n = 0;
      for (int i = 0; i < 8192; i++) seen[i] = 1'b0;
      cyc();
      seed_c = 13'h0001; seed_load_c = 1'b1; start_c = 1'b1;
      cyc();
      seed_load_c = 1'b0; start_c = 1'b0;
      m_sig = 16'hFFFF;
      mp    = 13'h0001;
      while (done_c !== 1'b1 && n < 9000) begin
         if (busy_c === 1'b1) begin
            if (seen[pat_c]) repeats++;
            seen[pat_c] = 1'b1;
            if (pat_c !== mp) bad++;
            m_sig = sisr_step(m_sig, core_f(mp, 1'b1));
            mp    = lfsr_step(mp);
         end
         n++;
         cyc();
      end
      checks++;
      if (done_c !== 1'b1) begin
         errors++; $display("FAIL period_timeout: got done=%b after %0d cycles expected 1", done_c, n);
      end
      checks++;
      if (n !== 8191) begin
         errors++; $display("FAIL period_busy_len: got %0d expected 8191", n);
      end
      checks++;
      if (repeats !== 0 || bad !== 0) begin
         errors++; $display("FAIL period_scoreboard: got repeats=%0d mismatches=%0d expected 0 0", repeats, bad);
      end
      checks++;
      if (pat_c !== 13'h0001) begin
         errors++; $display("FAIL period_wrap: got %h expected 0001", pat_c);
      end
      checks++;
      if (sig_c !== m_sig || pass_c !== (m_sig == 16'h0000)) begin
         errors++; $display("FAIL period_signature: got %h pass=%b expected %h", sig_c, pass_c, m_sig);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; seed_load = 1'b0; seed = '0; resp = 1'b0;
      start_c = 1'b0; seed_load_c = 1'b0; seed_c = '0;
      ma_lfsr = 13'h0001;
      cyc();
      cyc();
      rst = 1'b0;
      test_reset();
      test_pattern_seq();
      test_random_resp();
      test_ignored();
      test_reset_midrun();
      test_period();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
